// File: rtl/manche_fsm_pkg.sv
// Shared encodings and constants for the rock-paper-scissors match controller.
package manche_fsm_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    ROCK     = 2'b01,
    PAPER    = 2'b10,
    SCISSORS = 2'b11
  } move_e;

  typedef enum logic [1:0] {
    M_INVALID = 2'b00,
    M_P1      = 2'b01,
    M_P2      = 2'b10,
    M_DRAW    = 2'b11
  } manche_e;

  typedef enum logic [1:0] {
    G_RUN  = 2'b00,
    G_P1   = 2'b01,
    G_P2   = 2'b10,
    G_DRAW = 2'b11
  } partita_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_e;

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] MIN_ROUNDS = 5'd4;
  localparam logic [CNT_W-1:0] WIN_MARGIN = 5'd2;

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == ROCK     && b == SCISSORS) ||
           (a == SCISSORS && b == PAPER)    ||
           (a == PAPER    && b == ROCK);
  endfunction

endpackage

// File: rtl/manche_fsm_judge.sv
// Combinational round referee: turns both moves plus the remembered last winner
// into a round result code.
module manche_judge
  import manche_fsm_pkg::*;
(
  input  logic       primo_i,
  input  logic [1:0] primo_mv_i,
  input  logic [1:0] secondo_mv_i,
  input  logic       win_vld_i,
  input  logic       win_p2_i,
  input  logic [1:0] win_move_i,
  output logic [1:0] result_o
);

  logic [1:0] winner_mv;
  logic       repeat_mv;

  assign winner_mv = win_p2_i ? secondo_mv_i : primo_mv_i;
  assign repeat_mv = win_vld_i && (winner_mv == win_move_i);

  // A repeated winning move voids the round unless both players showed the same move.
  always_comb begin
    result_o = M_INVALID;
    if (primo_i && primo_mv_i != NONE && secondo_mv_i != NONE) begin
      if (primo_mv_i == secondo_mv_i)            result_o = M_DRAW;
      else if (repeat_mv)                         result_o = M_INVALID;
      else if (beats(primo_mv_i, secondo_mv_i))   result_o = M_P1;
      else                                        result_o = M_P2;
    end
  end

endmodule

// File: rtl/manche_fsm.sv
// Match controller: game-length load, round/win counters, end-of-game detection
// and registered MANCHE/PARTITA outputs.
module manche_fsm
  import manche_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       INIZIA,
  input  logic [1:0] PRIMO,
  input  logic [1:0] SECONDO,
  output logic [1:0] MANCHE,
  output logic [1:0] PARTITA
);

  state_e           state_q = IDLE;
  state_e           state_d;
  logic [CNT_W-1:0] max_q = '0;
  logic [CNT_W-1:0] played_q = '0, played_d;
  logic [CNT_W-1:0] w1_q = '0, w1_d;
  logic [CNT_W-1:0] w2_q = '0, w2_d;
  logic             win_vld_q = 1'b0, win_vld_d;
  logic             win_p2_q = 1'b0, win_p2_d;
  logic [1:0]       win_move_q = NONE, win_move_d;
  logic [1:0]       manche_q = M_INVALID, manche_d;
  logic [1:0]       partita_q = G_RUN, partita_d;

  logic [1:0]       result;
  logic             round_ok, game_end;
  logic [CNT_W-1:0] played_n, w1_n, w2_n, lead;
  logic [1:0]       verdict;

  manche_judge u_judge (
    .primo_i      (state_q == PLAY),
    .primo_mv_i   (PRIMO),
    .secondo_mv_i (SECONDO),
    .win_vld_i    (win_vld_q),
    .win_p2_i     (win_p2_q),
    .win_move_i   (win_move_q),
    .result_o     (result)
  );

  // Counts as they would stand after this round, used for the end-of-game decision.
  assign round_ok = (result != M_INVALID);
  assign played_n = played_q + 5'd1;
  assign w1_n     = w1_q + {4'd0, result == M_P1};
  assign w2_n     = w2_q + {4'd0, result == M_P2};
  assign lead     = (w1_n >= w2_n) ? (w1_n - w2_n) : (w2_n - w1_n);
  assign game_end = round_ok &&
                    ((played_n >= MIN_ROUNDS && lead >= WIN_MARGIN) || played_n == max_q);
  assign verdict  = (w1_n > w2_n) ? G_P1 : (w2_n > w1_n) ? G_P2 : G_DRAW;

  always_ff @(posedge clk) begin
    if (INIZIA) begin
      state_q    <= PLAY;
      max_q      <= MIN_ROUNDS + {1'b0, PRIMO, SECONDO};
      played_q   <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      win_vld_q  <= 1'b0;
      win_p2_q   <= 1'b0;
      win_move_q <= NONE;
      manche_q   <= M_INVALID;
      partita_q  <= G_RUN;
    end else begin
      state_q    <= state_d;
      played_q   <= played_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      win_vld_q  <= win_vld_d;
      win_p2_q   <= win_p2_d;
      win_move_q <= win_move_d;
      manche_q   <= manche_d;
      partita_q  <= partita_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    played_d   = played_q;
    w1_d       = w1_q;
    w2_d       = w2_q;
    win_vld_d  = win_vld_q;
    win_p2_d   = win_p2_q;
    win_move_d = win_move_q;
    if (state_q == PLAY && round_ok) begin
      played_d = played_n;
      w1_d     = w1_n;
      w2_d     = w2_n;
      unique case (result)
        M_P1: begin
          win_vld_d  = 1'b1;
          win_p2_d   = 1'b0;
          win_move_d = PRIMO;
        end
        M_P2: begin
          win_vld_d  = 1'b1;
          win_p2_d   = 1'b1;
          win_move_d = SECONDO;
        end
        default: win_vld_d = 1'b0;
      endcase
      if (game_end) state_d = OVER;
    end
  end

  always_comb begin
    manche_d  = M_INVALID;
    partita_d = partita_q;
    case (state_q)
      PLAY: begin
        manche_d = result;
        if (game_end) partita_d = verdict;
      end
      OVER:    partita_d = partita_q;
      default: partita_d = G_RUN;
    endcase
  end

  assign MANCHE  = manche_q;
  assign PARTITA = partita_q;

endmodule

// File: tb/tb_manche_fsm.sv
// Bench for manche_fsm: directed vector table followed by random rounds against a
// move-arithmetic reference model.
module tb_manche_fsm;

  logic       clk = 1'b0;
  logic       INIZIA = 1'b0;
  logic [1:0] PRIMO = 2'b00;
  logic [1:0] SECONDO = 2'b00;
  logic [1:0] MANCHE, PARTITA;

  int n_checks = 0;
  int n_fail   = 0;

  manche_fsm dut (
    .clk     (clk),
    .INIZIA  (INIZIA),
    .PRIMO   (PRIMO),
    .SECONDO (SECONDO),
    .MANCHE  (MANCHE),
    .PARTITA (PARTITA)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ini;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] em;
    logic [1:0] ep;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ini, input logic [1:0] p1, input logic [1:0] p2,
                     input logic [1:0] em, input logic [1:0] ep);
    vec_t v;
    v.ini = ini; v.p1 = p1; v.p2 = p2; v.em = em; v.ep = ep;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [1:0] act,
                       input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic apply(input logic ini, input logic [1:0] a, input logic [1:0] b);
    INIZIA  = ini;
    PRIMO   = a;
    SECONDO = b;
    @(posedge clk);
    #1;
  endtask

  // Reference model: moves mapped to 0..2 so "a beats b" is (a-b) mod 3 == 1.
  int         m_max, m_played, m_w1, m_w2, m_last_who, m_last_mv;
  bit         m_over;
  logic [1:0] m_part;

  task automatic model_step(input logic ini, input logic [1:0] a, input logic [1:0] b,
                            output logic [1:0] em, output logic [1:0] ep);
    int ra, rb, diff;
    bit repeated;
    if (ini) begin
      m_max = 4 + int'({a, b});
      m_played = 0; m_w1 = 0; m_w2 = 0; m_last_who = 0; m_last_mv = 0;
      m_over = 0; m_part = 2'b00;
      em = 2'b00; ep = 2'b00;
      return;
    end
    ep = m_part;
    em = 2'b00;
    if (m_over || a == 2'b00 || b == 2'b00) return;
    ra = int'(a) - 1;
    rb = int'(b) - 1;
    repeated = (m_last_who == 1 && int'(a) == m_last_mv) ||
               (m_last_who == 2 && int'(b) == m_last_mv);
    if (ra == rb) begin
      em = 2'b11;
      m_last_who = 0;
    end else if (repeated) begin
      return;
    end else if (((ra - rb + 3) % 3) == 1) begin
      em = 2'b01; m_w1++; m_last_who = 1; m_last_mv = int'(a);
    end else begin
      em = 2'b10; m_w2++; m_last_who = 2; m_last_mv = int'(b);
    end
    m_played++;
    diff = (m_w1 > m_w2) ? m_w1 - m_w2 : m_w2 - m_w1;
    if ((m_played >= 4 && diff >= 2) || m_played == m_max) begin
      m_over = 1;
      m_part = (m_w1 > m_w2) ? 2'b01 : (m_w2 > m_w1) ? 2'b10 : 2'b11;
    end
    ep = m_part;
  endtask

  initial begin
    logic [1:0] em, ep, ra, rb;
    logic       ri;

    #1;
    check("powerup_manche", 0, MANCHE, 2'b00);
    check("powerup_partita", 0, PARTITA, 2'b00);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 2'b01, 2'b11);
      check("idle_manche", i, MANCHE, 2'b00);
      check("idle_partita", i, PARTITA, 2'b00);
    end

    // Load MAX=6 then a draw
    add(1, 2'b00, 2'b10, 2'b00, 2'b00);
    add(0, 2'b01, 2'b01, 2'b11, 2'b00);
    // Full MAX=6 game ending in a P2 margin win, then OVER holds
    add(1, 2'b00, 2'b10, 2'b00, 2'b00);
    add(0, 2'b11, 2'b10, 2'b01, 2'b00);
    add(0, 2'b01, 2'b10, 2'b10, 2'b00);
    add(0, 2'b11, 2'b01, 2'b10, 2'b00);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 2'b01, 2'b01, 2'b11, 2'b00);
    add(0, 2'b01, 2'b10, 2'b10, 2'b10);
    add(0, 2'b10, 2'b01, 2'b00, 2'b10);
    // MAX=4: repeated winning move is void and not counted
    add(1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 2'b01, 2'b00);
    add(0, 2'b01, 2'b10, 2'b00, 2'b00);
    add(0, 2'b10, 2'b01, 2'b01, 2'b00);
    add(0, 2'b11, 2'b11, 2'b11, 2'b00);
    add(0, 2'b11, 2'b11, 2'b11, 2'b01);
    // MAX=19: two early P1 wins do not end; 3-1 after 4 rounds does
    add(1, 2'b11, 2'b11, 2'b00, 2'b00);
    add(0, 2'b10, 2'b01, 2'b01, 2'b00);
    add(0, 2'b11, 2'b10, 2'b01, 2'b00);
    add(0, 2'b10, 2'b11, 2'b10, 2'b00);
    add(0, 2'b11, 2'b10, 2'b01, 2'b01);
    add(0, 2'b01, 2'b11, 2'b00, 2'b01);
    // MAX=4 ending level on wins
    add(1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 2'b01, 2'b01, 2'b11, 2'b00);
    add(0, 2'b10, 2'b10, 2'b11, 2'b00);
    add(0, 2'b01, 2'b11, 2'b01, 2'b00);
    add(0, 2'b11, 2'b01, 2'b10, 2'b11);
    // Mid-game restart clears counters and the remembered winner
    add(1, 2'b00, 2'b10, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 2'b01, 2'b00);
    add(0, 2'b10, 2'b01, 2'b01, 2'b00);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 2'b10, 2'b11, 2'b10, 2'b00);
    add(0, 2'b11, 2'b01, 2'b10, 2'b00);
    add(0, 2'b10, 2'b10, 2'b11, 2'b00);
    add(0, 2'b11, 2'b11, 2'b11, 2'b10);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].ini, vecs[i].p1, vecs[i].p2);
      check("vec_manche", i, MANCHE, vecs[i].em);
      check("vec_partita", i, PARTITA, vecs[i].ep);
    end

    for (int i = 0; i < 3000; i++) begin
      ri = (i == 0) || ($urandom_range(0, 24) == 0);
      ra = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      model_step(ri, ra, rb, em, ep);
      apply(ri, ra, rb);
      check("rand_manche", i, MANCHE, em);
      check("rand_partita", i, PARTITA, ep);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
